// File: rtl/ex_stage_if.sv
// Bundles around the execute stage: ID->EX issue, EX->MEM pipeline register, data-RAM request.
// The master side drives the payload and valid/req; the slave side returns ready/flush.

interface ex_pipe_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              ready;
   logic              flush;
   logic              valid;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   instruction;
   logic [3:0]        alu_opcode;
   logic [XLEN-1:0]   op1;
   logic [XLEN-1:0]   op2;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic [XLEN-1:0]   imm;
   logic              branch;
   logic [2:0]        branch_opcode;
   logic              jal;
   logic              jalr;
   logic              mem_read;
   logic              mem_write;
   logic [2:0]        mem_opcode;
   logic              unsign;
   logic              rd_write;
   logic [REG_AW-1:0] rd_addr;

   modport master (
      input  ready, flush,
      output valid, pc, instruction, alu_opcode, op1, op2, rs1_data, rs2_data, imm,
             branch, branch_opcode, jal, jalr, mem_read, mem_write, mem_opcode,
             unsign, rd_write, rd_addr
   );

   modport slave (
      output ready, flush,
      input  valid, pc, instruction, alu_opcode, op1, op2, rs1_data, rs2_data, imm,
             branch, branch_opcode, jal, jalr, mem_read, mem_write, mem_opcode,
             unsign, rd_write, rd_addr
   );
endinterface

interface mem_pipe_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              ready;
   logic              flush;
   logic              valid;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   instruction;
   logic              mem_read;
   logic [2:0]        mem_opcode;
   logic [1:0]        mem_byte_addr;
   logic              unsign;
   logic              rd_write;
   logic [REG_AW-1:0] rd_addr;
   logic [XLEN-1:0]   alu_result;

   modport master (
      input  ready, flush,
      output valid, pc, instruction, mem_read, mem_opcode, mem_byte_addr,
             unsign, rd_write, rd_addr, alu_result
   );

   modport slave (
      output ready, flush,
      input  valid, pc, instruction, mem_read, mem_opcode, mem_byte_addr,
             unsign, rd_write, rd_addr, alu_result
   );
endinterface

interface dram_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            write;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      wstrb;
   logic            ready;

   modport master (output req, write, addr, wdata, wstrb, input ready);
   modport slave  (input req, write, addr, wdata, wstrb, output ready);
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, branch resolution, data-RAM request and EX->MEM register.
// Optional multiplier (ops 10-13, two-cycle) enabled by defining EX_MUL_EN.

module ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_b,
   ex_pipe_if.slave          ex_pipe,
   mem_pipe_if.master        mem_pipe,
   dram_if.master            dram,
   output logic              ex_branch_take,
   output logic [XLEN-1:0]   ex_branch_pc,
   output logic              ex_rd_write,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic [XLEN-1:0]   ex_rd_wdata,
   output logic              ex_mem_read
);

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_MUL    = 4'd10,
      ALU_MULH   = 4'd11,
      ALU_MULHSU = 4'd12,
      ALU_MULHU  = 4'd13,
      ALU_PASS   = 4'd14
   } alu_op_e;

   logic            ex_valid;
   logic            mem_access;
   logic            ex_done;
   logic            ex_fire;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] mem_addr;
   logic [1:0]      byte_addr;
   logic            branch_cond;
   logic [XLEN-1:0] store_data;
   logic [3:0]      store_strb;
   logic [4:0]      shamt;

   assign ex_valid   = ex_pipe.valid & ~mem_pipe.flush;
   assign mem_access = ex_pipe.mem_read | ex_pipe.mem_write;
   assign ex_fire    = ex_valid & ex_done & mem_pipe.ready;
   assign shamt      = ex_pipe.op2[4:0];

   assign ex_pipe.ready = ~ex_valid | ex_fire;
   assign ex_pipe.flush = mem_pipe.flush | ex_branch_take;

`ifdef EX_MUL_EN
   typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;

   mul_state_e mul_state;
   mul_state_e mul_state_next;
   logic       is_mul;
   logic       mul_load;
   logic       mul_done;
   logic       mul_sign_a;
   logic       mul_sign_b;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] mul_prod_q;

   assign is_mul = ex_pipe.alu_opcode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) mul_state <= MUL_IDLE;
      else        mul_state <= mul_state_next;
   end

   always_comb begin
      mul_state_next = mul_state;
      unique case (mul_state)
         MUL_IDLE: if (ex_valid && is_mul) mul_state_next = MUL_BUSY;
         MUL_BUSY: if (mem_pipe.flush || ex_fire) mul_state_next = MUL_IDLE;
         default:  mul_state_next = MUL_IDLE;
      endcase
   end

   always_comb begin
      mul_load = (mul_state == MUL_IDLE) & ex_valid & is_mul;
      mul_done = (mul_state == MUL_BUSY);
   end

   // Sign-extending both operands to 64 bits makes the low half of one product serve all four ops.
   assign mul_sign_a = (ex_pipe.alu_opcode != ALU_MULHU);
   assign mul_sign_b = (ex_pipe.alu_opcode == ALU_MUL) | (ex_pipe.alu_opcode == ALU_MULH);
   assign mul_a = {{32{mul_sign_a & ex_pipe.op1[31]}}, ex_pipe.op1};
   assign mul_b = {{32{mul_sign_b & ex_pipe.op2[31]}}, ex_pipe.op2};

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)        mul_prod_q <= '0;
      else if (mul_load) mul_prod_q <= mul_a * mul_b;
   end

   assign ex_done = (~mem_access | dram.ready) & (~is_mul | mul_done);
`else
   assign ex_done = ~mem_access | dram.ready;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      alu_result = '0;
      case (ex_pipe.alu_opcode)
         ALU_ADD:    alu_result = ex_pipe.op1 + ex_pipe.op2;
         ALU_SUB:    alu_result = ex_pipe.op1 - ex_pipe.op2;
         ALU_SLL:    alu_result = ex_pipe.op1 << shamt;
         ALU_SLT:    alu_result = {31'b0, $signed(ex_pipe.op1) < $signed(ex_pipe.op2)};
         ALU_SLTU:   alu_result = {31'b0, ex_pipe.op1 < ex_pipe.op2};
         ALU_XOR:    alu_result = ex_pipe.op1 ^ ex_pipe.op2;
         ALU_SRL:    alu_result = ex_pipe.op1 >> shamt;
         ALU_SRA:    alu_result = $unsigned($signed(ex_pipe.op1) >>> shamt);
         ALU_OR:     alu_result = ex_pipe.op1 | ex_pipe.op2;
         ALU_AND:    alu_result = ex_pipe.op1 & ex_pipe.op2;
         ALU_PASS:   alu_result = ex_pipe.op2;
`ifdef EX_MUL_EN
         ALU_MUL:    alu_result = mul_prod_q[31:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  alu_result = mul_prod_q[63:32];
`endif
         default:    alu_result = '0;
      endcase
   end

   always_comb begin
      branch_cond = 1'b0;
      case (ex_pipe.branch_opcode)
         3'b000:  branch_cond = (ex_pipe.rs1_data == ex_pipe.rs2_data);
         3'b001:  branch_cond = (ex_pipe.rs1_data != ex_pipe.rs2_data);
         3'b100:  branch_cond = ($signed(ex_pipe.rs1_data) <  $signed(ex_pipe.rs2_data));
         3'b101:  branch_cond = ($signed(ex_pipe.rs1_data) >= $signed(ex_pipe.rs2_data));
         3'b110:  branch_cond = (ex_pipe.rs1_data <  ex_pipe.rs2_data);
         3'b111:  branch_cond = (ex_pipe.rs1_data >= ex_pipe.rs2_data);
         default: branch_cond = 1'b0;
      endcase
   end

   assign ex_branch_take = ex_fire & (ex_pipe.jal | ex_pipe.jalr | (ex_pipe.branch & branch_cond));
   assign ex_branch_pc   = ex_pipe.jalr ? ((ex_pipe.rs1_data + ex_pipe.imm) & ~32'd1)
                                        : (ex_pipe.pc + ex_pipe.imm);

   assign mem_addr  = ex_pipe.op1 + ex_pipe.op2;
   assign byte_addr = mem_addr[1:0];

   // Misaligned halves/words are not trapped: only the lane-select bits of the address matter.
   always_comb begin
      store_data = ex_pipe.rs2_data;
      store_strb = 4'b1111;
      if (ex_pipe.mem_opcode[0]) begin
         store_data = {4{ex_pipe.rs2_data[7:0]}};
         store_strb = 4'b0001 << byte_addr;
      end else if (ex_pipe.mem_opcode[1]) begin
         store_data = {2{ex_pipe.rs2_data[15:0]}};
         store_strb = byte_addr[1] ? 4'b1100 : 4'b0011;
      end
      if (!ex_pipe.mem_write) store_strb = 4'b0000;
   end

   // Requests wait for MEM to be ready so the response lands while the instruction sits in MEM.
   assign dram.req   = ex_valid & mem_access & mem_pipe.ready;
   assign dram.write = ex_pipe.mem_write;
   assign dram.addr  = {mem_addr[31:2], 2'b00};
   assign dram.wdata = store_data;
   assign dram.wstrb = store_strb;

   assign ex_rd_write = ex_pipe.valid & ex_pipe.rd_write;
   assign ex_rd_addr  = ex_pipe.rd_addr;
   assign ex_rd_wdata = alu_result;
   assign ex_mem_read = ex_pipe.valid & ex_pipe.mem_read;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)              mem_pipe.valid <= 1'b0;
      else if (mem_pipe.ready) mem_pipe.valid <= ex_fire;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_pipe.pc            <= '0;
         mem_pipe.instruction   <= '0;
         mem_pipe.mem_read      <= 1'b0;
         mem_pipe.mem_opcode    <= '0;
         mem_pipe.mem_byte_addr <= '0;
         mem_pipe.unsign        <= 1'b0;
         mem_pipe.rd_write      <= 1'b0;
         mem_pipe.rd_addr       <= '0;
         mem_pipe.alu_result    <= '0;
      end else if (ex_fire) begin
         mem_pipe.pc            <= ex_pipe.pc;
         mem_pipe.instruction   <= ex_pipe.instruction;
         mem_pipe.mem_read      <= ex_pipe.mem_read;
         mem_pipe.mem_opcode    <= ex_pipe.mem_opcode;
         mem_pipe.mem_byte_addr <= byte_addr;
         mem_pipe.unsign        <= ex_pipe.unsign;
         mem_pipe.rd_write      <= ex_pipe.rd_write;
         mem_pipe.rd_addr       <= ex_pipe.rd_addr;
         mem_pipe.alu_result    <= alu_result;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus hand sequences for stalls, branches and flush.

module tb_ex_stage;

   logic clk = 1'b0;
   logic rst_b;
   logic            ex_branch_take;
   logic [31:0]     ex_branch_pc;
   logic            ex_rd_write;
   logic [4:0]      ex_rd_addr;
   logic [31:0]     ex_rd_wdata;
   logic            ex_mem_read;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cnt = 0;
   int cnt_before;

   ex_pipe_if  #(.XLEN(32), .REG_AW(5)) ex_pipe_bus ();
   mem_pipe_if #(.XLEN(32), .REG_AW(5)) mem_pipe_bus ();
   dram_if     #(.XLEN(32))             dram_bus ();

   ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .ex_pipe        (ex_pipe_bus),
      .mem_pipe       (mem_pipe_bus),
      .dram           (dram_bus),
      .ex_branch_take (ex_branch_take),
      .ex_branch_pc   (ex_branch_pc),
      .ex_rd_write    (ex_rd_write),
      .ex_rd_addr     (ex_rd_addr),
      .ex_rd_wdata    (ex_rd_wdata),
      .ex_mem_read    (ex_mem_read)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dram_bus.req && dram_bus.ready) acc_cnt <= acc_cnt + 1;
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } alu_vec_t;

   alu_vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      ex_pipe_bus.valid         = 1'b0;
      ex_pipe_bus.pc            = '0;
      ex_pipe_bus.instruction   = '0;
      ex_pipe_bus.alu_opcode    = '0;
      ex_pipe_bus.op1           = '0;
      ex_pipe_bus.op2           = '0;
      ex_pipe_bus.rs1_data      = '0;
      ex_pipe_bus.rs2_data      = '0;
      ex_pipe_bus.imm           = '0;
      ex_pipe_bus.branch        = 1'b0;
      ex_pipe_bus.branch_opcode = '0;
      ex_pipe_bus.jal           = 1'b0;
      ex_pipe_bus.jalr          = 1'b0;
      ex_pipe_bus.mem_read      = 1'b0;
      ex_pipe_bus.mem_write     = 1'b0;
      ex_pipe_bus.mem_opcode    = '0;
      ex_pipe_bus.unsign        = 1'b0;
      ex_pipe_bus.rd_write      = 1'b0;
      ex_pipe_bus.rd_addr       = '0;
      mem_pipe_bus.ready        = 1'b1;
      mem_pipe_bus.flush        = 1'b0;
      dram_bus.ready            = 1'b1;
   endtask

   task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      set_idle();
      ex_pipe_bus.valid      = 1'b1;
      ex_pipe_bus.alu_opcode = op;
      ex_pipe_bus.op1        = a;
      ex_pipe_bus.op2        = b;
      ex_pipe_bus.rd_write   = 1'b1;
      ex_pipe_bus.rd_addr    = 5'd7;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_wrap"};
      vecs[1]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap"};
      vecs[2]  = '{4'd2,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, "sll_shamt5"};
      vecs[3]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt"};
      vecs[4]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu"};
      vecs[5]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"};
      vecs[6]  = '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srl"};
      vecs[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, "sra"};
      vecs[8]  = '{4'd8,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, "or"};
      vecs[9]  = '{4'd14, 32'h0000_DEAD, 32'hABCD_E000, 32'hABCD_E000, "pass_lui"};
      vecs[10] = '{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, "op15_zero"};
      vecs[11] = '{4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};

      set_idle();
      rst_b = 1'b0;
      #1;
      check("rst_mem_valid",  {31'b0, mem_pipe_bus.valid}, 32'd0);
      check("rst_alu_result", mem_pipe_bus.alu_result, 32'd0);
      check("rst_pc",         mem_pipe_bus.pc, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      check("idle_ex_ready", {31'b0, ex_pipe_bus.ready}, 32'd1);
      step();

      for (int i = 0; i < 12; i++) begin
         set_alu(vecs[i].op, vecs[i].a, vecs[i].b);
         @(negedge clk);
         check({vecs[i].name, "_fwd"}, ex_rd_wdata, vecs[i].exp);
         check({vecs[i].name, "_rdw"}, {31'b0, ex_rd_write}, 32'd1);
         step();
         check({vecs[i].name, "_valid"}, {31'b0, mem_pipe_bus.valid}, 32'd1);
         check({vecs[i].name, "_res"}, mem_pipe_bus.alu_result, vecs[i].exp);
      end

      // MEM not ready: EX stalls and the pipeline register holds the AND result.
      set_alu(4'd0, 32'd1, 32'd2);
      mem_pipe_bus.ready = 1'b0;
      @(negedge clk);
      check("stall_ex_ready", {31'b0, ex_pipe_bus.ready}, 32'd0);
      step();
      check("stall_hold_valid", {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("stall_hold_res", mem_pipe_bus.alu_result, 32'hF000_F000);
      mem_pipe_bus.ready = 1'b1;
      @(negedge clk);
      check("unstall_ex_ready", {31'b0, ex_pipe_bus.ready}, 32'd1);
      step();
      check("unstall_res", mem_pipe_bus.alu_result, 32'd3);

      // SB to 0x1003
      set_alu(4'd0, 32'h0000_1000, 32'h0000_0003);
      ex_pipe_bus.rd_write   = 1'b0;
      ex_pipe_bus.mem_write  = 1'b1;
      ex_pipe_bus.mem_opcode = 3'b001;
      ex_pipe_bus.rs2_data   = 32'h0000_00A5;
      @(negedge clk);
      check("sb_req",   {31'b0, dram_bus.req}, 32'd1);
      check("sb_write", {31'b0, dram_bus.write}, 32'd1);
      check("sb_addr",  dram_bus.addr, 32'h0000_1000);
      check("sb_wstrb", {28'b0, dram_bus.wstrb}, 32'h8);
      check("sb_wdata", dram_bus.wdata, 32'hA5A5_A5A5);
      step();
      check("sb_valid", {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("sb_baddr", {30'b0, mem_pipe_bus.mem_byte_addr}, 32'd3);

      // SH to 0x1006 picks the upper half lanes.
      set_alu(4'd0, 32'h0000_1004, 32'h0000_0002);
      ex_pipe_bus.mem_write  = 1'b1;
      ex_pipe_bus.mem_opcode = 3'b010;
      ex_pipe_bus.rs2_data   = 32'h1234_BEEF;
      @(negedge clk);
      check("sh_addr",  dram_bus.addr, 32'h0000_1004);
      check("sh_wstrb", {28'b0, dram_bus.wstrb}, 32'hC);
      check("sh_wdata", dram_bus.wdata, 32'hBEEF_BEEF);
      step();

      // LH from 0x2002 with three wait cycles on the RAM.
      cnt_before = acc_cnt;
      set_alu(4'd0, 32'h0000_2000, 32'h0000_0002);
      ex_pipe_bus.mem_read   = 1'b1;
      ex_pipe_bus.mem_opcode = 3'b010;
      dram_bus.ready         = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("lh_wait_ex_ready", {31'b0, ex_pipe_bus.ready}, 32'd0);
         check("lh_wait_req",      {31'b0, dram_bus.req}, 32'd1);
         check("lh_wait_wstrb",    {28'b0, dram_bus.wstrb}, 32'd0);
         check("lh_mem_read_fwd",  {31'b0, ex_mem_read}, 32'd1);
         step();
         check("lh_wait_valid", {31'b0, mem_pipe_bus.valid}, 32'd0);
      end
      dram_bus.ready = 1'b1;
      @(negedge clk);
      check("lh_ex_ready", {31'b0, ex_pipe_bus.ready}, 32'd1);
      step();
      check("lh_valid",    {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("lh_baddr",    {30'b0, mem_pipe_bus.mem_byte_addr}, 32'd2);
      check("lh_memread",  {31'b0, mem_pipe_bus.mem_read}, 32'd1);
      check("lh_accepted", acc_cnt - cnt_before, 32'd1);

      // BLT taken on signed compare.
      set_idle();
      ex_pipe_bus.valid         = 1'b1;
      ex_pipe_bus.branch        = 1'b1;
      ex_pipe_bus.branch_opcode = 3'b100;
      ex_pipe_bus.rs1_data      = 32'hFFFF_FFFF;
      ex_pipe_bus.rs2_data      = 32'h0000_0001;
      ex_pipe_bus.pc            = 32'h0000_0100;
      ex_pipe_bus.imm           = 32'h0000_0020;
      @(negedge clk);
      check("blt_take",  {31'b0, ex_branch_take}, 32'd1);
      check("blt_pc",    ex_branch_pc, 32'h0000_0120);
      check("blt_flush", {31'b0, ex_pipe_bus.flush}, 32'd1);
      step();
      ex_pipe_bus.valid = 1'b0;
      @(negedge clk);
      check("blt_one_cycle", {31'b0, ex_branch_take}, 32'd0);
      step();
      ex_pipe_bus.valid         = 1'b1;
      ex_pipe_bus.branch_opcode = 3'b110;
      @(negedge clk);
      check("bltu_take",  {31'b0, ex_branch_take}, 32'd0);
      check("bltu_flush", {31'b0, ex_pipe_bus.flush}, 32'd0);
      step();

      // JALR clears bit 0 of the target; link value comes from the ALU.
      set_alu(4'd0, 32'h0000_0300, 32'h0000_0004);
      ex_pipe_bus.jalr     = 1'b1;
      ex_pipe_bus.pc       = 32'h0000_0300;
      ex_pipe_bus.rs1_data = 32'h0000_1001;
      ex_pipe_bus.imm      = 32'h0000_0010;
      @(negedge clk);
      check("jalr_take", {31'b0, ex_branch_take}, 32'd1);
      check("jalr_pc",   ex_branch_pc, 32'h0000_1010);
      step();
      check("jalr_link", mem_pipe_bus.alu_result, 32'h0000_0304);

      // Downstream flush beats a taken JAL.
      set_alu(4'd0, 32'h0000_0200, 32'h0000_0004);
      ex_pipe_bus.jal    = 1'b1;
      ex_pipe_bus.pc     = 32'h0000_0200;
      ex_pipe_bus.imm    = 32'h0000_0040;
      mem_pipe_bus.flush = 1'b1;
      @(negedge clk);
      check("flush_jal_take",  {31'b0, ex_branch_take}, 32'd0);
      check("flush_jal_req",   {31'b0, dram_bus.req}, 32'd0);
      check("flush_jal_flush", {31'b0, ex_pipe_bus.flush}, 32'd1);
      check("flush_ex_ready",  {31'b0, ex_pipe_bus.ready}, 32'd1);
      step();
      check("flush_jal_valid", {31'b0, mem_pipe_bus.valid}, 32'd0);
      ex_pipe_bus.mem_write = 1'b1;
      @(negedge clk);
      check("flush_store_req", {31'b0, dram_bus.req}, 32'd0);
      step();
      ex_pipe_bus.mem_write = 1'b0;
      mem_pipe_bus.flush    = 1'b0;
      @(negedge clk);
      check("jal_take", {31'b0, ex_branch_take}, 32'd1);
      check("jal_pc",   ex_branch_pc, 32'h0000_0240);
      step();

`ifdef EX_MUL_EN
      set_alu(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      check("mulh_stall_ready", {31'b0, ex_pipe_bus.ready}, 32'd0);
      step();
      check("mulh_stall_valid", {31'b0, mem_pipe_bus.valid}, 32'd0);
      @(negedge clk);
      check("mulh_done_ready", {31'b0, ex_pipe_bus.ready}, 32'd1);
      step();
      check("mulh_valid", {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("mulh_res",   mem_pipe_bus.alu_result, 32'h0000_0000);
      set_alu(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      check("mulhu_stall_ready", {31'b0, ex_pipe_bus.ready}, 32'd0);
      step();
      step();
      check("mulhu_valid", {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("mulhu_res",   mem_pipe_bus.alu_result, 32'hFFFF_FFFE);
`else
      set_alu(4'd10, 32'd3, 32'd5);
      @(negedge clk);
      check("mul_off_ready", {31'b0, ex_pipe_bus.ready}, 32'd1);
      check("mul_off_fwd",   ex_rd_wdata, 32'd0);
      step();
      check("mul_off_valid", {31'b0, mem_pipe_bus.valid}, 32'd1);
      check("mul_off_res",   mem_pipe_bus.alu_result, 32'd0);
`endif

      set_idle();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
